fft64_reorder_ctrl: RTL and testbench
=====================================

# fft64_reorder_ctrl

Ping-pong controller that sequences two single-port RAM64 banks into a 64-point frame reorder buffer at the FFT64 output. It writes each incoming frame in natural order into one bank while reading the previous frame from the other bank in bit-reversed order. It also produces the output-mux select, a per-sample valid and a first-sample marker, all aligned to the RAM's 2-ED-cycle read latency.

## Interface
- BITREV, 1, read order: 1 = bit-reversed address, 0 = natural order (bypass/debug)
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  synchronous reset, active-low
- ED  in  1  enable, common with the RAM banks; when 0, every register holds its value
- START  in  1  frame start, sampled only when ED=1; the first sample arrives at the next ED=1 cycle
- ADDR0  out  6  bank 0 address (registered)
- WE0  out  1  bank 0 write enable (registered)
- ADDR1  out  6  bank 1 address (registered)
- WE1  out  1  bank 1 write enable (registered)
- OSEL  out  1  selects which bank's DO drives the block output; aligned to DO
- VALID  out  1  the selected DO holds a reordered sample
- RDY  out  1  the selected DO holds sample 0 of a reordered frame

## Operation
- Internal state: st ∈ {IDLE, FILL, STREAM}, wcnt[5:0], rcnt[5:0], wb (write bank; read bank = ~wb), 2-stage ED-enabled pipeline of {rd_act, rcnt==0, ~wb}.
- IDLE: both WE=0, both ADDR=0. START moves to FILL with wcnt=0 and wb=0.
- FILL: on each ED cycle, bank wb gets WE=1 and ADDR=wcnt, and wcnt increments. The other bank gets WE=0 and ADDR=0, with no read. When wcnt wraps 63→0: wb toggles and st moves to STREAM with rcnt=0.
- STREAM: on each ED cycle:
  - Bank wb is written at wcnt.
  - Bank ~wb is read: WE=0, ADDR = BITREV ? {rcnt[0],rcnt[1],…,rcnt[5]} : rcnt.
  - Both counters increment. On wrap 63→0, wb toggles and reading continues with rcnt=0 on the newly full bank.
  - Streaming continues indefinitely without further START.
- START while in FILL or STREAM: abort and resynchronise.
  - st=FILL, wcnt=0; wb is kept.
  - The read side stops at once, and the pipeline's rd_act inputs become 0.
  - Samples already in the pipeline still drain.
- Output pipeline: stage1 captures {rd_act, rcnt==0, ~wb} for the address issued in the current ED cycle. Stage2 copies stage1. VALID, RDY and OSEL are driven from stage2.
- RSTn=0 at any edge, including mid-frame: st=IDLE, all counters 0, wb=0, pipeline cleared. Reset takes priority over ED and START.

## Timing
- Reset values: ADDR0=ADDR1=0, WE0=WE1=0, OSEL=0, VALID=0, RDY=0.
- ADDRx/WEx are registered, so they reflect the state decided at the previous ED edge. DI for sample n must be applied in the cycle where ADDRx=n and WEx=1.
- START accepted at ED cycle t. Sample 0 is written in ED cycle t+1, sample 63 in t+64. The first read address is issued in ED cycle t+65, together with the write of sample 64 into the other bank.
- Read latency: the address issued in ED cycle n appears on DO after the ED edge ending ED cycle n+1. VALID, RDY and OSEL change on that same edge.
- With ED=0, outputs hold. RDY therefore stays high for as long as DO holds sample 0.
- Throughput: 1 sample per ED cycle, with no bubbles between frames. Frame latency is 64 + 2 ED cycles from first-sample write to first reordered output.
- START coinciding with a wcnt wrap: START wins. There is no bank swap and st=FILL.

## Test plan
- Reset: hold RSTn=0 with ED=1 and START=1 for 3 cycles. Required: all outputs 0 and st=IDLE. Release: the block stays idle with ADDR0=ADDR1=0.
- Single frame, BITREV=1, ED=1, DI=n at write n:
  - Writes go to bank 0 at addresses 0..63.
  - Bank 0 reads 0,32,16,48,…,63.
  - Output sequence is 0,32,16,…,63, with RDY only on the first sample and VALID for 64 cycles.
- Continuous 3 frames, DI=64f+n:
  - Banks alternate every 64 ED cycles; OSEL toggles aligned to the RDY pulses.
  - There is no gap in VALID between frames 0 and 1.
- ED gating: randomise ED at 50% duty over 2 frames. Required: the same output sequence as the ED=1 case, and no write or address change during ED=0.
- START mid-STREAM at wcnt=20:
  - VALID drops 2 ED cycles later.
  - The next write uses address 0 of the same bank.
  - Output resumes 66 ED cycles after the restart with the new frame in bit-reversed order.
- BITREV=0 single frame: read addresses 0..63 in order, and the outputs equal the inputs delayed by 66 ED cycles.

Source files
------------

// File: rtl/fft64_reorder_ctrl_if.sv
// fft64_reorder_ctrl_if
// Control/status bundle between the FFT64 reorder controller and the rest of
// the output stage (RAM64 banks and output mux).
//   START   frame start request (sampled on ED cycles)
//   BITREV  read order: 1 = bit-reversed, 0 = natural (bypass/debug)
//   ADDR0/WE0, ADDR1/WE1  registered address / write enable per RAM bank
//   OSEL    output mux select, aligned to the RAM data-out
//   VALID   selected data-out holds a reordered sample
//   RDY     selected data-out holds sample 0 of a reordered frame
// master: the controller side; slave: the RAM/mux/consumer side.
interface fft64_reorder_ctrl_if;
  logic       START;
  logic       BITREV;
  logic [5:0] ADDR0;
  logic       WE0;
  logic [5:0] ADDR1;
  logic       WE1;
  logic       OSEL;
  logic       VALID;
  logic       RDY;

  modport master (
    input  START, BITREV,
    output ADDR0, WE0, ADDR1, WE1, OSEL, VALID, RDY
  );

  modport slave (
    output START, BITREV,
    input  ADDR0, WE0, ADDR1, WE1, OSEL, VALID, RDY
  );
endinterface

// File: rtl/fft64_reorder_ctrl.sv
// fft64_reorder_ctrl
// Ping-pong sequencer for two single-port RAM64 banks forming the 64-point
// reorder buffer behind the FFT64. Each frame is written in natural order into
// one bank while the previous frame is read from the other bank in bit-reversed
// (or natural) order. Streaming continues without further START.
// Ports:
//   CLK   clock, all state on the rising edge
//   RSTn  synchronous reset, active-low, priority over ED and START
//   ED    clock enable shared with the RAM banks; ED=0 freezes every register
//   bus   fft64_reorder_ctrl_if.master (START, BITREV in; bank addresses,
//         write enables, OSEL, VALID, RDY out)
module fft64_reorder_ctrl (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        ED,
  fft64_reorder_ctrl_if.master        bus
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} st_t;

  st_t        st, st_n;
  logic [5:0] wcnt, wcnt_n;
  logic [5:0] rcnt, rcnt_n;
  logic       wb, wb_n;

  logic [5:0] addr0_q, addr1_q, addr0_n, addr1_n;
  logic       we0_q, we1_q, we0_n, we1_n;
  logic [5:0] rd_addr;
  logic       rd_act;

  logic       vld_p1, first_p1, bank_p1;
  logic       vld_p2, first_p2, bank_p2;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    return {a[0], a[1], a[2], a[3], a[4], a[5]};
  endfunction

  // Next state plus the bank addressing for the cycle that state describes.
  // The address/WE registers are loaded from the next state so that, in every
  // cycle, ADDRx/WEx already show the access belonging to that cycle.
  always_comb begin
    st_n   = st;
    wcnt_n = wcnt;
    rcnt_n = rcnt;
    wb_n   = wb;

    if (bus.START) begin
      // Restart: a fresh frame begins at address 0. From IDLE it goes to
      // bank 0; mid-stream the current write bank is kept (no swap, even
      // when START lands on the wrap).
      st_n   = FILL;
      wcnt_n = 6'd0;
      rcnt_n = 6'd0;
      wb_n   = (st == IDLE) ? 1'b0 : wb;
    end else begin
      case (st)
        FILL: begin
          wcnt_n = wcnt + 6'd1;
          if (wcnt == 6'd63) begin
            wb_n   = ~wb;
            st_n   = STREAM;
            rcnt_n = 6'd0;
          end
        end
        STREAM: begin
          wcnt_n = wcnt + 6'd1;
          rcnt_n = rcnt + 6'd1;
          if (wcnt == 6'd63) wb_n = ~wb;
        end
        default: ;
      endcase
    end

    rd_addr = bus.BITREV ? bitrev6(rcnt_n) : rcnt_n;

    we0_n   = 1'b0;
    we1_n   = 1'b0;
    addr0_n = 6'd0;
    addr1_n = 6'd0;
    if (st_n != IDLE) begin
      if (wb_n) begin
        we1_n   = 1'b1;
        addr1_n = wcnt_n;
      end else begin
        we0_n   = 1'b1;
        addr0_n = wcnt_n;
      end
    end
    if (st_n == STREAM) begin
      if (wb_n) addr0_n = rd_addr;
      else      addr1_n = rd_addr;
    end

    // A read issued in a START cycle is abandoned; only older reads drain.
    rd_act = (st == STREAM) && !bus.START;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      st       <= IDLE;
      wcnt     <= 6'd0;
      rcnt     <= 6'd0;
      wb       <= 1'b0;
      addr0_q  <= 6'd0;
      addr1_q  <= 6'd0;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      bank_p1  <= 1'b0;
      vld_p2   <= 1'b0;
      first_p2 <= 1'b0;
      bank_p2  <= 1'b0;
    end else if (ED) begin
      st      <= st_n;
      wcnt    <= wcnt_n;
      rcnt    <= rcnt_n;
      wb      <= wb_n;
      addr0_q <= addr0_n;
      addr1_q <= addr1_n;
      we0_q   <= we0_n;
      we1_q   <= we1_n;
      // stage 1: tag of the read address issued in the current ED cycle
      vld_p1   <= rd_act;
      first_p1 <= (rcnt == 6'd0);
      bank_p1  <= ~wb;
      // stage 2: aligned with RAM data-out (2 ED-cycle read latency)
      vld_p2   <= vld_p1;
      first_p2 <= first_p1;
      bank_p2  <= bank_p1;
    end
  end

  assign bus.ADDR0 = addr0_q;
  assign bus.WE0   = we0_q;
  assign bus.ADDR1 = addr1_q;
  assign bus.WE1   = we1_q;
  assign bus.OSEL  = bank_p2;
  assign bus.VALID = vld_p2;
  assign bus.RDY   = vld_p2 & first_p2;

endmodule

// File: tb/tb_fft64_reorder_ctrl.sv
// tb_fft64_reorder_ctrl
// Bench for fft64_reorder_ctrl: two behavioural RAM64 banks with a 2 ED-cycle
// read latency, a stimulus process that pushes the expected reordered frame
// (value, first flag, bank, due ED edge) into a queue, and a monitor that pops
// and compares whenever the expected output is due.
module tb_fft64_reorder_ctrl;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  logic ED   = 1'b0;
  always #5 CLK = ~CLK;

  fft64_reorder_ctrl_if bus();

  fft64_reorder_ctrl dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .ED   (ED),
    .bus  (bus)
  );

  // RAM64 bank models
  logic [15:0] DI;
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  logic [15:0] rd0_a, do0, rd1_a, do1;
  logic [15:0] dout;

  always @(posedge CLK) begin
    if (ED) begin
      if (bus.WE0) mem0[bus.ADDR0] <= DI;
      if (bus.WE1) mem1[bus.ADDR1] <= DI;
      rd0_a <= mem0[bus.ADDR0];
      rd1_a <= mem1[bus.ADDR1];
      do0   <= rd0_a;
      do1   <= rd1_a;
    end
  end
  assign dout = bus.OSEL ? do1 : do0;

  typedef struct {
    int due;
    int val;
    int first;
    int bank;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;
  int   seq   = 0;
  int   dbase = 0;
  logic active  = 1'b0;
  logic tb_bank = 1'b0;
  logic [16:0] snap = '0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int br(input int k);
    int r = 0;
    for (int i = 0; i < 6; i++) if (k[i]) r = r | (1 << (5 - i));
    return r;
  endfunction

  function automatic logic [16:0] outs();
    return {bus.ADDR0, bus.WE0, bus.ADDR1, bus.WE1, bus.OSEL, bus.VALID, bus.RDY};
  endfunction

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RSTn) begin
        chk("reset_outs", int'(outs()), 0);
      end else if (!ED) begin
        chk("ed_hold", int'(outs()), int'(snap));
      end else begin
        ecnt++;
        while (q.size() != 0 && q[0].due < ecnt) begin
          chk("late_sample_due", ecnt, q[0].due);
          q.delete(0);
        end
        if (q.size() != 0 && q[0].due == ecnt) begin
          chk("valid", int'(bus.VALID), 1);
          chk("data", int'(dout), q[0].val);
          chk("rdy", int'(bus.RDY), q[0].first);
          chk("osel", int'(bus.OSEL), q[0].bank);
          q.delete(0);
        end else begin
          chk("valid_idle", int'(bus.VALID), 0);
        end
      end
      snap = outs();
    end
  end

  // One clock cycle of stimulus; inputs change on the falling edge.
  task automatic cyc(input logic s, input logic e);
    @(negedge CLK);
    RSTn      = 1'b1;
    bus.START = s;
    ED        = e;
    DI        = 16'(dbase + seq);
    if (e) begin
      if (s) begin
        // reads issued from this cycle on never reach the output
        while (q.size() != 0 && q[q.size()-1].due >= ecnt + 2) q.delete(q.size() - 1);
        if (!active) tb_bank = 1'b0;
        active = 1'b1;
        seq    = 0;
      end else if (active) begin
        if (seq % 64 == 63) begin
          for (int k = 0; k < 64; k++) begin
            exp_t x;
            x.due   = ecnt + 3 + k;
            x.val   = (dbase + seq - 63 + (bus.BITREV ? br(k) : k)) & 16'hffff;
            x.first = (k == 0) ? 1 : 0;
            x.bank  = int'(tb_bank);
            q.push_back(x);
          end
          tb_bank = ~tb_bank;
        end
        seq++;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RSTn      = 1'b0;
      ED        = 1'b1;
      bus.START = 1'b1;
    end
    q.delete();
    active  = 1'b0;
    seq     = 0;
    tb_bank = 1'b0;
  endtask

  task automatic edge_chk();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    int n_ed;
    int guard;
    logic e;
    bus.START  = 1'b0;
    bus.BITREV = 1'b1;
    DI         = '0;

    // reset with ED and START asserted, then idle after release
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1);
      edge_chk();
      chk("idle_addr0", int'(bus.ADDR0), 0);
      chk("idle_addr1", int'(bus.ADDR1), 0);
      chk("idle_we", int'({bus.WE0, bus.WE1}), 0);
    end

    // single frame, bit-reversed
    dbase = 0;
    cyc(1'b1, 1'b1);
    for (int j = 0; j < 64; j++) begin
      edge_chk();
      chk("fill_addr0", int'(bus.ADDR0), j);
      chk("fill_we", int'({bus.WE0, bus.WE1}), 2);
      cyc(1'b0, 1'b1);
    end
    for (int k = 0; k < 64; k++) begin
      edge_chk();
      chk("rd_addr0_bitrev", int'(bus.ADDR0), br(k));
      chk("rd_wr_addr1", int'(bus.ADDR1), k);
      chk("rd_we", int'({bus.WE0, bus.WE1}), 1);
      cyc(1'b0, 1'b1);
    end
    repeat (4) cyc(1'b0, 1'b1);
    do_reset(2);

    // three continuous frames
    dbase = 0;
    cyc(1'b1, 1'b1);
    repeat (260) cyc(1'b0, 1'b1);
    do_reset(2);

    // ED gated at ~50% over two frames
    dbase = 1000;
    cyc(1'b1, 1'b1);
    n_ed  = 0;
    guard = 0;
    while (n_ed < 196 && guard < 2000) begin
      e = 1'($urandom_range(0, 1));
      cyc(1'b0, e);
      if (e) n_ed++;
      guard++;
    end
    do_reset(2);

    // restart mid-stream at wcnt=20
    dbase = 2000;
    cyc(1'b1, 1'b1);
    repeat (84) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    edge_chk();
    chk("restart20_we", int'({bus.WE0, bus.WE1}), 1);
    chk("restart20_addr1", int'(bus.ADDR1), 0);
    repeat (140) cyc(1'b0, 1'b1);
    do_reset(2);

    // restart coinciding with the wcnt wrap: no bank swap
    dbase = 3000;
    cyc(1'b1, 1'b1);
    repeat (127) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    edge_chk();
    chk("restart63_we", int'({bus.WE0, bus.WE1}), 1);
    chk("restart63_addr1", int'(bus.ADDR1), 0);
    repeat (140) cyc(1'b0, 1'b1);
    do_reset(2);

    // natural-order read
    bus.BITREV = 1'b0;
    dbase = 500;
    cyc(1'b1, 1'b1);
    repeat (64) cyc(1'b0, 1'b1);
    for (int k = 0; k < 64; k++) begin
      edge_chk();
      chk("rd_addr0_natural", int'(bus.ADDR0), k);
      chk("rd_we0_natural", int'(bus.WE0), 0);
      cyc(1'b0, 1'b1);
    end
    repeat (4) cyc(1'b0, 1'b1);
    do_reset(2);
    repeat (2) cyc(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
